// File: rtl/gray_decoder_rx_if.sv
// Signal bundle between a Gray-coded counter source and its receiver.
// The master drives gray_in/gray_vld; the slave returns the decoded count and stream status.
interface gray_decoder_rx_if #(
    parameter int CBITS = 9,
    parameter int ECW   = 8
);
    logic [CBITS-1:0] gray_in;
    logic             gray_vld;
    logic [CBITS-1:0] bin_out;
    logic             bin_vld;
    logic             locked;
    logic             wrap;
    logic             step_err;
    logic [ECW-1:0]   err_cnt;
    logic [1:0]       state_dbg;

    // gray_vld is a strobe with no back-pressure: every cycle it is high,
    // the receiver samples gray_in. bin_vld pulses one cycle per sample.
    modport master (
        output gray_in, gray_vld,
        input  bin_out, bin_vld, locked, wrap, step_err, err_cnt, state_dbg
    );

    modport slave (
        input  gray_in, gray_vld,
        output bin_out, bin_vld, locked, wrap, step_err, err_cnt, state_dbg
    );
endinterface

// File: rtl/gray_decoder_rx.sv
// Gray-to-binary receiver that proves the incoming count advances by +1
// before declaring lock, and flags wrap-around and step errors.
module gray_decoder_rx #(
    parameter int CBITS  = 9,
    parameter int LOCK_N = 4,
    parameter int ECW    = 8
) (
    input logic               clk,
    input logic               rst,
    gray_decoder_rx_if.slave  bus
);
    localparam int RW = $clog2(LOCK_N + 1);

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [RW-1:0]    run_q, run_nxt;
    logic             have_prev_q;
    logic [CBITS-1:0] prev_bin_q;
    logic [CBITS-1:0] bin_q;
    logic             bin_vld_q;
    logic             wrap_q, wrap_nxt;
    logic             err_q, err_nxt;
    logic [ECW-1:0]   err_cnt_q;

    logic [CBITS-1:0] dec;
    logic             good, hold, bad;

    // Each binary bit is the parity of the Gray bits at and above it.
    always_comb begin
        dec = '0;
        for (int i = 0; i < CBITS; i++) begin
            dec[i] = ^(bus.gray_in >> i);
        end
    end

    always_comb begin
        good = 1'b0;
        hold = 1'b0;
        bad  = 1'b0;
        if (bus.gray_vld && have_prev_q) begin
            good = (dec == prev_bin_q + 1'b1);
            hold = (dec == prev_bin_q);
            bad  = !good && !hold;
        end
    end

    always_comb begin
        state_nxt = state_q;
        run_nxt   = run_q;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (bus.gray_vld) begin
            wrap_nxt = good && (prev_bin_q == '1) && (dec == '0);
            err_nxt  = bad;
            case (state_q)
                SEEK: begin
                    state_nxt = ACQ;
                    run_nxt   = '0;
                end
                ACQ: begin
                    if (good) begin
                        run_nxt = run_q + 1'b1;
                        if (run_q + 1'b1 == RW'(LOCK_N)) state_nxt = LOCK;
                    end else if (bad) begin
                        run_nxt = '0;
                    end
                end
                LOCK: begin
                    if (bad) begin
                        state_nxt = ACQ;
                        run_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = SEEK;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEEK;
            run_q       <= '0;
            have_prev_q <= 1'b0;
            prev_bin_q  <= '0;
            bin_q       <= '0;
            bin_vld_q   <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q   <= state_nxt;
            run_q     <= run_nxt;
            bin_vld_q <= bus.gray_vld;
            wrap_q    <= wrap_nxt;
            err_q     <= err_nxt;
            if (bus.gray_vld) begin
                have_prev_q <= 1'b1;
                prev_bin_q  <= dec;
                bin_q       <= dec;
            end
            if (bad && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.bin_out   = bin_q;
    assign bus.bin_vld   = bin_vld_q;
    assign bus.locked    = (state_q == LOCK);
    assign bus.wrap      = wrap_q;
    assign bus.step_err  = err_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.state_dbg = state_q;
endmodule
